// File: rtl/fft_frame_pkg.sv
`default_nettype none
// ============================================================================
// fft_frame_pkg : shared types and helpers for the FFT frame packer
// Rev 1.0
// ============================================================================
package fft_frame_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        DROP = 2'd2
    } state_e;

    function automatic int cnt_width(input int max_log2);
        return max_log2 + 1;
    endfunction

    localparam int MAX_LOG2_DEFAULT = 12;
    localparam int CNT_W            = cnt_width(MAX_LOG2_DEFAULT);

    function automatic int clamp_log2(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_pipe_reg.sv
`default_nettype none
// ============================================================================
// axis_pipe_reg : single-stage valid/ready register for an AXI-Stream payload
// Rev 1.0
// ============================================================================
module axis_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Slot is free when empty or being drained this cycle.
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_frame_packer.sv
`default_nettype none
// ============================================================================
// fft_frame_packer : frames ADC chirps into fixed-length FFT frames (pad/truncate)
// Rev 1.0
// ============================================================================
module fft_frame_packer
    import fft_frame_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MIN_LOG2 = 3,
    parameter int MAX_LOG2 = 12,
    parameter int USER_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(MAX_LOG2+1)-1:0] cfg_log2_len,
    input  logic                         cfg_pad_en,
    input  logic                         cfg_trunc_en,
    input  logic [2*DATA_W-1:0]          s_tdata,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic                         s_tlast,
    output logic [2*DATA_W-1:0]          m_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         m_tlast,
    output logic [USER_W-1:0]            m_tuser,
    output logic                         err_short,
    output logic                         err_long
);

    localparam int LEN_W  = cnt_width(MAX_LOG2);
    localparam int LOG2_W = $clog2(MAX_LOG2 + 1);
    localparam int PAY_W  = USER_W + 1 + 2 * DATA_W;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LOG2_W-1:0]   log2_q;
    logic                pad_q, trunc_q;
    logic [USER_W-1:0]   frame_q, frame_d;
    logic                run_q;
    logic                err_short_q, err_short_d;
    logic                err_long_q, err_long_d;

    logic                w_free;
    logic                w_first;
    logic                w_acc;
    logic [LOG2_W-1:0]   w_live_log2;
    logic [LOG2_W-1:0]   w_log2;
    logic                w_pad;
    logic                w_trunc;
    logic [LEN_W-1:0]    w_last_idx;
    logic                w_at_end;
    logic                w_ld;
    logic                w_ld_last;
    logic [2*DATA_W-1:0] w_ld_data;
    logic [PAY_W-1:0]    w_out;

    // The first sample of a frame decides using live config; the rest use the latched copy.
    assign w_live_log2 = LOG2_W'(clamp_log2(int'(cfg_log2_len), MIN_LOG2, MAX_LOG2));
    assign w_first     = (state_q == FILL) && (cnt_q == '0);
    assign w_log2      = w_first ? w_live_log2  : log2_q;
    assign w_pad       = w_first ? cfg_pad_en   : pad_q;
    assign w_trunc     = w_first ? cfg_trunc_en : trunc_q;
    assign w_last_idx  = LEN_W'((32'd1 << w_log2) - 32'd1);
    assign w_at_end    = (cnt_q == w_last_idx);

    assign s_tready  = run_q && (((state_q == FILL) && w_free) || (state_q == DROP));
    assign w_acc     = s_tvalid && s_tready;
    assign err_short = err_short_q;
    assign err_long  = err_long_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        w_ld        = 1'b0;
        w_ld_last   = 1'b0;
        w_ld_data   = '0;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        case (state_q)
            FILL: begin
                if (w_acc) begin
                    w_ld      = 1'b1;
                    w_ld_data = s_tdata;
                    if (w_at_end) begin
                        w_ld_last = 1'b1;
                        cnt_d     = '0;
                        if (!s_tlast) begin
                            err_long_d = 1'b1;
                            if (w_trunc) state_d = DROP;
                        end
                    end else if (s_tlast) begin
                        err_short_d = 1'b1;
                        if (w_pad) begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = PAD;
                        end else begin
                            w_ld_last = 1'b1;
                            cnt_d     = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PAD: begin
                if (run_q && w_free) begin
                    w_ld = 1'b1;
                    if (w_at_end) begin
                        w_ld_last = 1'b1;
                        cnt_d     = '0;
                        state_d   = FILL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DROP: begin
                if (w_acc && s_tlast) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
        // Frame index advances as its last beat enters the register, so the next beat carries the new index.
        if (w_ld && w_ld_last) frame_d = frame_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            log2_q      <= '0;
            pad_q       <= 1'b0;
            trunc_q     <= 1'b0;
            frame_q     <= '0;
            run_q       <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            run_q       <= 1'b1;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            if (w_first && w_acc) begin
                log2_q  <= w_live_log2;
                pad_q   <= cfg_pad_en;
                trunc_q <= cfg_trunc_en;
            end
        end
    end

    axis_pipe_reg #(
        .W (PAY_W)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (w_ld),
        .in_ready_o  (w_free),
        .in_data_i   ({frame_q, w_ld_last, w_ld_data}),
        .out_valid_o (m_tvalid),
        .out_ready_i (m_tready),
        .out_data_o  (w_out)
    );

    assign {m_tuser, m_tlast, m_tdata} = w_out;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_packer.sv
`default_nettype none
// ============================================================================
// tb_fft_frame_packer : directed self-checking bench for fft_frame_packer
// Rev 1.0
// ============================================================================
module tb_fft_frame_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cfg_log2_len = 4'd7;
    logic        cfg_pad_en = 1'b0;
    logic        cfg_trunc_en = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [15:0] m_tuser;
    logic        err_short;
    logic        err_long;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_frame = 0;
    bit rand_ready = 1'b0;

    logic [31:0] q_data[$];
    bit          q_last[$];
    logic [15:0] q_user[$];
    int n_short = 0, n_long = 0, n_srdy_low = 0, n_stall = 0;
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [31:0] pd = '0;
    logic [15:0] pu = '0;

    fft_frame_packer dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_log2_len (cfg_log2_len),
        .cfg_pad_en   (cfg_pad_en),
        .cfg_trunc_en (cfg_trunc_en),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tlast      (s_tlast),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .m_tuser      (m_tuser),
        .err_short    (err_short),
        .err_long     (err_long)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        m_tready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    end

    // Outputs are sampled on the falling edge, half a cycle from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            pv <= 1'b0;
        end else begin
            if (m_tvalid && m_tready) begin
                q_data.push_back(m_tdata);
                q_last.push_back(m_tlast);
                q_user.push_back(m_tuser);
            end
            if (pv && !pr && (!m_tvalid || m_tdata !== pd || m_tlast !== pl || m_tuser !== pu))
                n_stall <= n_stall + 1;
            pv <= m_tvalid;
            pr <= m_tready;
            pd <= m_tdata;
            pl <= m_tlast;
            pu <= m_tuser;
            if (err_short) n_short <= n_short + 1;
            if (err_long)  n_long  <= n_long + 1;
            if (!s_tready) n_srdy_low <= n_srdy_low + 1;
        end
    end

    task automatic drive_seq(input int n, input int base, input bit last_on_end, input bit rnd);
        bit acc;
        int guard;
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                while ($urandom_range(1, 0) == 0) begin
                    s_tvalid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            s_tdata  = 32'(base + i);
            s_tvalid = 1'b1;
            s_tlast  = last_on_end && (i == n - 1);
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 5000) begin
                @(negedge clk);
                acc = s_tready;
                @(posedge clk); #1;
                guard++;
            end
            n_cmp++;
            if (!acc) begin
                n_bad++;
                $display("FAIL drive_accept: s_tready=0 for 5000 cycles at sample %0d, required 1", i);
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                return;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int g = 0;
        while (q_data.size() < n && g < 6000) begin
            @(posedge clk);
            g++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({m_tvalid, m_tlast, err_short, err_long, s_tready} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: {vld,last,es,el,srdy}=%b, required 00000",
                     {m_tvalid, m_tlast, err_short, err_long, s_tready});
        end
        n_cmp++;
        if (m_tdata !== 32'd0 || m_tuser !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_data: tdata=%h tuser=%h, required 0/0", m_tdata, m_tuser);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_tready !== 1'b0) begin
            n_bad++;
            $display("FAIL sready_pre_edge: got %b, required 0", s_tready);
        end
        @(negedge clk);
        n_cmp++;
        if (s_tready !== 1'b1) begin
            n_bad++;
            $display("FAIL sready_post_edge: got %b, required 1", s_tready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_frames();
        int base = q_data.size();
        int s0 = n_short, l0 = n_long;
        int bad = 0, nl = 0;
        cfg_log2_len = 4'd7; cfg_pad_en = 1'b0; cfg_trunc_en = 1'b0;
        for (int c = 0; c < 3; c++) drive_seq(128, 1000 + 128 * c, 1'b1, 1'b0);
        wait_out(base + 384);
        n_cmp++;
        if (q_data.size() - base !== 384) begin
            n_bad++;
            $display("FAIL full_count: got %0d outputs, required 384", q_data.size() - base);
        end
        for (int k = 0; k < 384 && base + k < q_data.size(); k++) begin
            if (q_data[base+k] !== 32'(1000 + k) || q_last[base+k] !== (k % 128 == 127) ||
                q_user[base+k] !== 16'(exp_frame + k / 128)) bad++;
            if (q_last[base+k]) nl++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL full_seq: %0d bad beats, required 0", bad);
        end
        n_cmp++;
        if (nl !== 3) begin
            n_bad++;
            $display("FAIL full_tlast: got %0d tlast beats, required 3", nl);
        end
        n_cmp++;
        if (n_short - s0 !== 0 || n_long - l0 !== 0) begin
            n_bad++;
            $display("FAIL full_err: short=%0d long=%0d, required 0/0", n_short - s0, n_long - l0);
        end
        exp_frame += 3;
    endtask

    task automatic test_pad();
        int base = q_data.size();
        int s0 = n_short, l0 = n_long, r0 = n_srdy_low;
        int bad = 0;
        cfg_log2_len = 4'd4; cfg_pad_en = 1'b1; cfg_trunc_en = 1'b0;
        drive_seq(10, 1, 1'b1, 1'b0);
        wait_out(base + 16);
        n_cmp++;
        if (q_data.size() - base !== 16) begin
            n_bad++;
            $display("FAIL pad_count: got %0d outputs, required 16", q_data.size() - base);
        end
        for (int k = 0; k < 16 && base + k < q_data.size(); k++)
            if (q_data[base+k] !== (k < 10 ? 32'(k + 1) : 32'd0) || q_last[base+k] !== (k == 15) ||
                q_user[base+k] !== 16'(exp_frame)) bad++;
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL pad_seq: %0d bad beats, required 0", bad);
        end
        n_cmp++;
        if (n_short - s0 !== 1 || n_long - l0 !== 0) begin
            n_bad++;
            $display("FAIL pad_err: short=%0d long=%0d, required 1/0", n_short - s0, n_long - l0);
        end
        n_cmp++;
        if (n_srdy_low - r0 !== 6) begin
            n_bad++;
            $display("FAIL pad_sready: low %0d cycles, required 6", n_srdy_low - r0);
        end
        exp_frame += 1;

        // Smallest frame: requested log2 0 clamps to 3, a single sample pads to 8.
        base = q_data.size();
        bad = 0;
        cfg_log2_len = 4'd0;
        drive_seq(1, 77, 1'b1, 1'b0);
        wait_out(base + 8);
        n_cmp++;
        if (q_data.size() - base !== 8) begin
            n_bad++;
            $display("FAIL min_count: got %0d outputs, required 8", q_data.size() - base);
        end
        for (int k = 0; k < 8 && base + k < q_data.size(); k++)
            if (q_data[base+k] !== (k == 0 ? 32'd77 : 32'd0) || q_last[base+k] !== (k == 7) ||
                q_user[base+k] !== 16'(exp_frame)) bad++;
        n_cmp++;
        if (bad !== 0 || n_short - s0 !== 2) begin
            n_bad++;
            $display("FAIL min_seq: %0d bad beats, short=%0d, required 0/2", bad, n_short - s0);
        end
        exp_frame += 1;
    endtask

    task automatic test_trunc();
        int base = q_data.size();
        int s0 = n_short, l0 = n_long;
        int bad = 0;
        cfg_log2_len = 4'd4; cfg_pad_en = 1'b0; cfg_trunc_en = 1'b1;
        drive_seq(20, 100, 1'b1, 1'b0);
        drive_seq(16, 200, 1'b1, 1'b0);
        wait_out(base + 32);
        n_cmp++;
        if (q_data.size() - base !== 32) begin
            n_bad++;
            $display("FAIL trunc_count: got %0d outputs, required 32", q_data.size() - base);
        end
        for (int k = 0; k < 32 && base + k < q_data.size(); k++)
            if (q_data[base+k] !== (k < 16 ? 32'(100 + k) : 32'(200 + k - 16)) ||
                q_last[base+k] !== (k == 15 || k == 31) ||
                q_user[base+k] !== 16'(exp_frame + k / 16)) bad++;
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL trunc_seq: %0d bad beats, required 0", bad);
        end
        n_cmp++;
        if (n_long - l0 !== 1 || n_short - s0 !== 0) begin
            n_bad++;
            $display("FAIL trunc_err: long=%0d short=%0d, required 1/0", n_long - l0, n_short - s0);
        end
        exp_frame += 2;
    endtask

    task automatic test_backpressure();
        int base = q_data.size();
        int s0 = n_short, l0 = n_long, st0 = n_stall;
        int bad = 0;
        cfg_log2_len = 4'd6; cfg_pad_en = 1'b0; cfg_trunc_en = 1'b0;
        rand_ready = 1'b1;
        drive_seq(64, 32'h5000, 1'b1, 1'b1);
        drive_seq(64, 32'h5040, 1'b1, 1'b1);
        wait_out(base + 128);
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (q_data.size() - base !== 128) begin
            n_bad++;
            $display("FAIL bp_count: got %0d outputs, required 128", q_data.size() - base);
        end
        for (int k = 0; k < 128 && base + k < q_data.size(); k++)
            if (q_data[base+k] !== 32'(32'h5000 + k) || q_last[base+k] !== (k % 64 == 63) ||
                q_user[base+k] !== 16'(exp_frame + k / 64)) bad++;
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL bp_seq: %0d bad beats, required 0", bad);
        end
        n_cmp++;
        if (n_stall - st0 !== 0) begin
            n_bad++;
            $display("FAIL bp_stable: %0d unstable stall cycles, required 0", n_stall - st0);
        end
        n_cmp++;
        if (n_short - s0 !== 0 || n_long - l0 !== 0) begin
            n_bad++;
            $display("FAIL bp_err: short=%0d long=%0d, required 0/0", n_short - s0, n_long - l0);
        end
        exp_frame += 2;
    endtask

    task automatic test_clamp_cfg_change();
        int base = q_data.size();
        int s0 = n_short, l0 = n_long;
        int bad = 0, nl = 0;
        cfg_log2_len = 4'd4; cfg_pad_en = 1'b0; cfg_trunc_en = 1'b0;
        drive_seq(8, 300, 1'b0, 1'b0);
        cfg_log2_len = 4'd15;
        drive_seq(8, 308, 1'b1, 1'b0);
        drive_seq(4096, 32'h10000, 1'b1, 1'b0);
        wait_out(base + 16 + 4096);
        n_cmp++;
        if (q_data.size() - base !== 4112) begin
            n_bad++;
            $display("FAIL clamp_count: got %0d outputs, required 4112", q_data.size() - base);
        end
        for (int k = 0; k < 4112 && base + k < q_data.size(); k++) begin
            if (q_data[base+k] !== (k < 16 ? 32'(300 + k) : 32'(32'h10000 + k - 16)) ||
                q_last[base+k] !== (k == 15 || k == 4111) ||
                q_user[base+k] !== 16'(exp_frame + (k < 16 ? 0 : 1))) bad++;
            if (q_last[base+k]) nl++;
        end
        n_cmp++;
        if (bad !== 0 || nl !== 2) begin
            n_bad++;
            $display("FAIL clamp_seq: %0d bad beats, %0d tlast, required 0/2", bad, nl);
        end
        n_cmp++;
        if (n_short - s0 !== 0 || n_long - l0 !== 0) begin
            n_bad++;
            $display("FAIL clamp_err: short=%0d long=%0d, required 0/0", n_short - s0, n_long - l0);
        end
        exp_frame += 2;
    endtask

    task automatic test_reset_midframe();
        int base = q_data.size();
        int nl = 0, bad = 0;
        cfg_log2_len = 4'd7; cfg_pad_en = 1'b0; cfg_trunc_en = 1'b0;
        drive_seq(40, 2000, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({m_tvalid, m_tlast, err_short, err_long, s_tready} !== 5'b0 ||
            m_tdata !== 32'd0 || m_tuser !== 16'd0) begin
            n_bad++;
            $display("FAIL midrst_state: vld=%b last=%b srdy=%b data=%h user=%h, required all 0",
                     m_tvalid, m_tlast, s_tready, m_tdata, m_tuser);
        end
        for (int k = base; k < q_data.size(); k++) if (q_last[k]) nl++;
        n_cmp++;
        if (nl !== 0) begin
            n_bad++;
            $display("FAIL midrst_tlast: got %0d tlast beats, required 0", nl);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_frame = 0;
        @(posedge clk); #1;
        base = q_data.size();
        drive_seq(128, 3000, 1'b1, 1'b0);
        wait_out(base + 128);
        n_cmp++;
        if (q_data.size() - base !== 128) begin
            n_bad++;
            $display("FAIL midrst_count: got %0d outputs, required 128", q_data.size() - base);
        end
        for (int k = 0; k < 128 && base + k < q_data.size(); k++)
            if (q_data[base+k] !== 32'(3000 + k) || q_last[base+k] !== (k == 127) ||
                q_user[base+k] !== 16'(exp_frame)) bad++;
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL midrst_seq: %0d bad beats, required 0", bad);
        end
        exp_frame += 1;
    endtask

    initial begin
        test_reset();
        test_full_frames();
        test_pad();
        test_trunc();
        test_backpressure();
        test_clamp_cfg_change();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
